// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds opcode / REGIMM constants, the opALU codes consumed by the
// ALU-control decoder, the main FSM state enum, mux-select constants,
// the control-word struct and small decode helper functions.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // REGIMM sub-ops (IR[20:16])
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // opALU codes shared with the ALU-control decoder
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_RTYPE = 4'b0110;
  localparam logic [3:0] ALU_BGEZ  = 4'b0111;
  localparam logic [3:0] ALU_ADDU  = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SLTI  = 4'b1010;

  // Mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] DST_RT       = 2'b00;
  localparam logic [1:0] DST_RD       = 2'b01;
  localparam logic [1:0] DST_RA       = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] op_alu;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  // R-type funct codes the datapath implements
  function automatic logic funct_legal(input logic [5:0] funct);
    case (funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b001011: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  endfunction

  // DECODE dispatch; S_FETCH doubles as the "unsupported opcode" result
  function automatic state_t decode_next(input logic [5:0] opcode, input logic [4:0] rt);
    case (opcode)
      OP_LW, OP_SW: decode_next = S_MEM_ADDR;
      OP_RTYPE:     decode_next = S_R_EXEC;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_REGIMM: begin
        if ((rt == RT_BGEZ) || (rt == RT_BGEZAL)) begin
          decode_next = S_BRANCH;
        end else begin
          decode_next = S_FETCH;
        end
      end
      OP_J, OP_JAL: decode_next = S_JUMP;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI:
                    decode_next = S_I_EXEC;
      default:      decode_next = S_FETCH;
    endcase
  endfunction

  // opALU for the immediate-arithmetic group
  function automatic logic [3:0] iexec_op(input logic [5:0] opcode);
    case (opcode)
      OP_ADDI:  iexec_op = ALU_ADD;
      OP_ADDIU: iexec_op = ALU_ADDU;
      OP_ANDI:  iexec_op = ALU_AND;
      OP_ORI:   iexec_op = ALU_OR;
      OP_XORI:  iexec_op = ALU_XOR;
      OP_SLTI:  iexec_op = ALU_SLTI;
      OP_LUI:   iexec_op = ALU_LUI;
      default:  iexec_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder for the multicycle MIPS FSM.
// Inputs : i_state (current FSM state), i_opcode/i_funct/i_rt (IR fields),
//          i_alu_zero/i_alu_sign (branch resolution), i_mem_ready.
// Output : o_ctrl, the full datapath control word for this cycle.
// Everything is a Moore decode of the state except ir_write/pc_write in
// FETCH (qualified by mem_ready) and the resolved branch pc_write.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  input  logic       i_alu_zero,
  input  logic       i_alu_sign,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  // Decode state (plus IR fields where the spec needs them) into the control word
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.op_alu    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut
        o_ctrl.alu_src_b  = SRCB_IMM_SH2;
        o_ctrl.op_alu     = ALU_ADD;
        o_ctrl.illegal_op = (decode_next(i_opcode, i_rt) == S_FETCH);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.op_alu    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = DST_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_RT;
        o_ctrl.op_alu     = ALU_RTYPE;
        o_ctrl.illegal_op = ~funct_legal(i_funct);
      end
      S_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = DST_RD;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.op_alu    = iexec_op(i_opcode);
      end
      S_I_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = DST_RT;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        if (i_opcode == OP_BEQ) begin
          o_ctrl.op_alu   = ALU_SUB;
          o_ctrl.pc_write = i_alu_zero;
        end else begin
          o_ctrl.op_alu   = ALU_BGEZ;
          o_ctrl.pc_write = ~i_alu_sign;
        end
        // bgezal links whether or not the branch is taken
        if ((i_opcode == OP_REGIMM) && (i_rt == RT_BGEZAL)) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = DST_RA;
          o_ctrl.mem_to_reg = M2R_PC;
        end else begin
          o_ctrl.reg_write  = 1'b0;
        end
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
        if (i_opcode == OP_JAL) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = DST_RA;
          o_ctrl.mem_to_reg = M2R_PC;
        end else begin
          o_ctrl.reg_write  = 1'b0;
        end
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core.
// Ports: clk/rst_n (async active-low reset); IR fields opcode, funct, rt;
// ALU flags alu_zero/alu_sign; mem_ready handshake. Outputs are the
// datapath control word (memory requests, IR/PC/register enables, mux
// selects, op_alu), the illegal_op pulse and state_dbg.
// The state register and next-state logic live here; the control word
// comes from mips_ctrl_outdec.
module mips_multicycle_control #(
  parameter int OPALU_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               alu_zero,
  input  logic               alu_sign,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [OPALU_W-1:0] op_alu,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);
  import mips_ctrl_pkg::*;

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  // State register; reset forces FETCH immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; illegal opcode/funct and unreachable codes go to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = decode_next(opcode, rt);
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = funct_legal(funct) ? S_R_WB : S_FETCH;
      S_R_WB:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_funct     (funct),
    .i_rt        (rt),
    .i_alu_zero  (alu_zero),
    .i_alu_sign  (alu_sign),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign i_or_d     = w_ctrl.i_or_d;
  // Architectural writes are blocked while reset is held, even if mem_ready is high
  assign ir_write   = w_ctrl.ir_write  & rst_n;
  assign pc_write   = w_ctrl.pc_write  & rst_n;
  assign reg_write  = w_ctrl.reg_write & rst_n;
  assign pc_source  = w_ctrl.pc_source;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign op_alu     = OPALU_W'(w_ctrl.op_alu);
  assign reg_dst    = w_ctrl.reg_dst;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign illegal_op = w_ctrl.illegal_op;
  assign state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       alu_zero, alu_sign, mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src_a;
  logic       reg_write, illegal_op;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0] op_alu, state_dbg;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .op_alu(op_alu),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] op_alu;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       illegal_op;
  } exp_t;

  typedef struct {
    state_t st;
    logic   rdy;
    exp_t   e;
  } step_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_BGEZ = 5,
                 K_BGEZAL = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  logic [5:0] i_ops [7] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101,
                            6'b001110, 6'b001010, 6'b001111};
  logic [3:0] i_alu [7] = '{4'b0000, 4'b1000, 4'b0010, 4'b0100,
                            4'b0101, 4'b1010, 4'b1001};
  logic [5:0] ok_fn [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b001011};

  step_t      q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] cur_op, cur_fn;
  logic [4:0] cur_rt;
  logic       cur_z, cur_s;

  function automatic int classify(logic [5:0] op, logic [4:0] r);
    if (op == 6'b100011) return K_LW;
    if (op == 6'b101011) return K_SW;
    if (op == 6'b000000) return K_R;
    if (op == 6'b000100) return K_BEQ;
    if (op == 6'b000001 && r == 5'b00001) return K_BGEZ;
    if (op == 6'b000001 && r == 5'b10001) return K_BGEZAL;
    if (op == 6'b000010) return K_J;
    if (op == 6'b000011) return K_JAL;
    for (int k = 0; k < 7; k++) if (op == i_ops[k]) return K_I;
    return K_ILL;
  endfunction

  function automatic logic funct_ok(logic [5:0] f);
    for (int k = 0; k < 10; k++) if (f == ok_fn[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] i_code(logic [5:0] op);
    for (int k = 0; k < 7; k++) if (op == i_ops[k]) return i_alu[k];
    return 4'b0000;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(state_t st, logic rdy, exp_t e);
    step_t s;
    s.st = st; s.rdy = rdy; s.e = e;
    q.push_back(s);
  endtask

  // Reference model: expected per-cycle sequence for one instruction
  task automatic build(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic z, logic sg,
                       int fst, int mst);
    exp_t e;
    int   k;
    q.delete();
    k = classify(op, r);
    cur_op = op; cur_fn = fn; cur_rt = r; cur_z = z; cur_s = sg;
    for (int i = 0; i < fst; i++) begin
      e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      push(S_FETCH, 1'b0, e);
    end
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(S_FETCH, 1'b1, e);
    e = '0; e.alu_src_b = 2'b11; e.illegal_op = (k == K_ILL);
    push(S_DECODE, rbit(), e);
    case (k)
      K_LW, K_SW: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        push(S_MEM_ADDR, rbit(), e);
        e = '0; e.i_or_d = 1'b1;
        if (k == K_LW) begin
          e.mem_read = 1'b1;
          for (int i = 0; i < mst; i++) push(S_MEM_RD, 1'b0, e);
          push(S_MEM_RD, 1'b1, e);
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          push(S_MEM_WB, rbit(), e);
        end else begin
          e.mem_write = 1'b1;
          for (int i = 0; i < mst; i++) push(S_MEM_WR, 1'b0, e);
          push(S_MEM_WR, 1'b1, e);
        end
      end
      K_R: begin
        e = '0; e.alu_src_a = 1'b1; e.op_alu = 4'b0110; e.illegal_op = ~funct_ok(fn);
        push(S_R_EXEC, rbit(), e);
        if (funct_ok(fn)) begin
          e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01;
          push(S_R_WB, rbit(), e);
        end
      end
      K_I: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.op_alu = i_code(op);
        push(S_I_EXEC, rbit(), e);
        e = '0; e.reg_write = 1'b1;
        push(S_I_WB, rbit(), e);
      end
      K_BEQ, K_BGEZ, K_BGEZAL: begin
        e = '0; e.alu_src_a = 1'b1; e.pc_source = 2'b01;
        e.op_alu   = (k == K_BEQ) ? 4'b0001 : 4'b0111;
        e.pc_write = (k == K_BEQ) ? z : ~sg;
        if (k == K_BGEZAL) begin
          e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        end
        push(S_BRANCH, rbit(), e);
      end
      K_J, K_JAL: begin
        e = '0; e.pc_write = 1'b1; e.pc_source = 2'b10;
        if (k == K_JAL) begin
          e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        end
        push(S_JUMP, rbit(), e);
      end
      default: ;
    endcase
  endtask

  function automatic exp_t observed();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
            alu_src_b, op_alu, reg_write, reg_dst, mem_to_reg, illegal_op};
  endfunction

  // Drive and check the first n cycles of the expected sequence
  task automatic run(int n);
    exp_t obs;
    for (int i = 0; i < n && i < q.size(); i++) begin
      @(negedge clk);
      opcode = cur_op; funct = cur_fn; rt = cur_rt;
      alu_zero = cur_z; alu_sign = cur_s; mem_ready = q[i].rdy;
      #1;
      n_tests++;
      assert (state_dbg === 4'(q[i].st)) else begin
        n_fail++;
        $error("FAIL state[%0d] op=%b: observed %0d expected %0d (%s)",
               i, cur_op, state_dbg, 4'(q[i].st), q[i].st.name());
      end
      obs = observed();
      n_tests++;
      assert (obs === q[i].e) else begin
        n_fail++;
        $error("FAIL ctrl[%0d] %s op=%b fn=%b rt=%b: observed %h expected %h",
               i, q[i].st.name(), cur_op, cur_fn, cur_rt, obs, q[i].e);
      end
    end
  endtask

  task automatic do_instr(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic z,
                          logic sg, int fst, int mst);
    build(op, fn, r, z, sg, fst, mst);
    run(q.size());
  endtask

  exp_t e_fetch;
  int   sel;
  logic [5:0] rop, rfn;
  logic [4:0] rrt;

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0; rt = 5'd0;
    alu_zero = 1'b0; alu_sign = 1'b0;
    e_fetch = '0; e_fetch.mem_read = 1'b1; e_fetch.alu_src_b = 2'b01;

    // Reset state
    #12;
    n_tests++;
    assert (state_dbg === 4'd0) else begin
      n_fail++; $error("FAIL reset_state: observed %0d expected 0", state_dbg);
    end
    n_tests++;
    assert (observed() === e_fetch) else begin
      n_fail++; $error("FAIL reset_ctrl: observed %h expected %h", observed(), e_fetch);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // lw: 3 fetch stalls, 2 memory stalls
    do_instr(6'b100011, 6'd0, 5'd0, 1'b0, 1'b0, 3, 2);
    // R-type sub, then unsupported funct
    do_instr(6'b000000, 6'b100010, 5'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'b000000, 6'b111111, 5'd0, 1'b0, 1'b0, 1, 0);
    // I-type sweep
    for (int k = 0; k < 7; k++) do_instr(i_ops[k], 6'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    // Branches
    do_instr(6'b000100, 6'd0, 5'd0, 1'b1, 1'b0, 0, 0);
    do_instr(6'b000100, 6'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'b000001, 6'd0, 5'b10001, 1'b0, 1'b1, 0, 0);
    do_instr(6'b000001, 6'd0, 5'b00001, 1'b0, 1'b0, 0, 0);
    // Jumps and an illegal opcode
    do_instr(6'b000010, 6'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'b000011, 6'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'b111111, 6'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'b000001, 6'd0, 5'b00000, 1'b0, 1'b0, 0, 0);

    // Reset asserted while a store waits in MEM_WR
    build(6'b101011, 6'd0, 5'd0, 1'b0, 1'b0, 0, 4);
    run(5);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    assert (mem_write === 1'b0) else begin
      n_fail++; $error("FAIL rst_mid_wr_memwrite: observed %b expected 0", mem_write);
    end
    n_tests++;
    assert (state_dbg === 4'd0) else begin
      n_fail++; $error("FAIL rst_mid_wr_state: observed %0d expected 0", state_dbg);
    end
    n_tests++;
    assert ({pc_write, reg_write, ir_write, mem_read} === 4'b0001) else begin
      n_fail++; $error("FAIL rst_mid_wr_enables: observed %b expected 0001",
                       {pc_write, reg_write, ir_write, mem_read});
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_instr(6'b101011, 6'd0, 5'd0, 1'b0, 1'b0, 1, 2);

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 9);
      rfn = 6'($urandom_range(0, 63));
      rrt = 5'($urandom_range(0, 31));
      case (sel)
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: begin
          rop = 6'b000000;
          if (rbit()) rfn = ok_fn[$urandom_range(0, 9)];
        end
        3: rop = i_ops[$urandom_range(0, 6)];
        4: rop = 6'b000100;
        5: begin
          rop = 6'b000001;
          if (rbit()) rrt = rbit() ? 5'b10001 : 5'b00001;
        end
        6: rop = 6'b000010;
        7: rop = 6'b000011;
        8: rop = 6'($urandom_range(0, 63));
        default: rop = 6'b111111;
      endcase
      do_instr(rop, rfn, rrt, rbit(), rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
